// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode, state and ALU select definitions for the processor controller
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5
    } opcode_e;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_LOAD_A    = 4'd3,
        S_LOAD_B    = 4'd4,
        S_STORE     = 4'd5,
        S_ALU_OP    = 4'd6,
        S_HALT      = 4'd7,
        S_WAIT_STEP = 4'd8
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/ir_reg.sv
// rtl/ir_reg.sv - load-enable instruction register with async active-low clear
module ir_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture the instruction word only when the controller is fetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - multicycle controller; PROC_CTRL_STEP_EN adds single-step Step input
module proc_ctrl
    import proc_pkg::*;
#(
    parameter int PC_W    = 7,
    parameter int DADDR_W = 8,
    parameter int RF_AW   = 4
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [15:0]        Instr,
`ifdef PROC_CTRL_STEP_EN
    input  logic               Step,
`endif
    output logic               PC_Clr,
    output logic               PC_Up,
    output logic [DADDR_W-1:0] D_Addr,
    output logic               D_Wr,
    output logic               RF_s,
    output logic [RF_AW-1:0]   RF_W_Addr,
    output logic               RF_W_en,
    output logic [RF_AW-1:0]   RF_Ra_Addr,
    output logic [RF_AW-1:0]   RF_Rb_Addr,
    output logic [2:0]         ALU_s0,
    output logic [3:0]         OutState
);

    // Address fields are sliced straight out of the 16-bit instruction word
    if (DADDR_W != 8 || RF_AW != 4 || PC_W < 1) begin : g_bad_params
        $error("proc_ctrl: DADDR_W must be 8, RF_AW must be 4, PC_W must be positive");
    end

`ifdef PROC_CTRL_STEP_EN
    localparam state_e S_DONE = S_WAIT_STEP;
`else
    localparam state_e S_DONE = S_FETCH;
`endif

    state_e      state;
    state_e      state_next;
    logic        ir_load;
    logic [15:0] ir;
    opcode_e     op;

    ir_reg #(.W(16)) u_ir (
        .clk   (Clk),
        .rst_n (Reset_n),
        .load  (ir_load),
        .d     (Instr),
        .q     (ir)
    );

    assign op       = opcode_e'(ir[15:12]);
    assign OutState = state;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Address outputs follow the IR fields so they settle before any write enable
    always_comb begin
        D_Addr     = '0;
        RF_W_Addr  = '0;
        RF_Ra_Addr = '0;
        RF_Rb_Addr = '0;
        case (op)
            OP_LOAD: begin
                D_Addr    = ir[11:4];
                RF_W_Addr = ir[3:0];
            end
            OP_STORE: begin
                D_Addr     = ir[11:4];
                RF_Ra_Addr = ir[3:0];
            end
            OP_ADD, OP_SUB: begin
                RF_Ra_Addr = ir[11:8];
                RF_Rb_Addr = ir[7:4];
                RF_W_Addr  = ir[3:0];
            end
            default: ;
        endcase
    end

    // Next-state and enable decode; enables are forced low while reset is held
    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        PC_Clr     = 1'b0;
        PC_Up      = 1'b0;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        ALU_s0     = ALU_PASS;
        case (state)
            S_INIT: begin
                PC_Clr     = 1'b1;
                PC_Up      = 1'b1;
                state_next = S_DONE;
            end
            S_FETCH: begin
                ir_load    = 1'b1;
                PC_Up      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:        state_next = S_LOAD_A;
                    OP_STORE:       state_next = S_STORE;
                    OP_ADD, OP_SUB: state_next = S_ALU_OP;
                    OP_HALT:        state_next = S_HALT;
                    default:        state_next = S_DONE;
                endcase
            end
            S_LOAD_A: begin
                state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                RF_s       = 1'b1;
                RF_W_en    = 1'b1;
                state_next = S_DONE;
            end
            S_STORE: begin
                D_Wr       = 1'b1;
                state_next = S_DONE;
            end
            S_ALU_OP: begin
                RF_W_en    = 1'b1;
                ALU_s0     = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                state_next = S_DONE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
`ifdef PROC_CTRL_STEP_EN
            S_WAIT_STEP: begin
                if (Step) begin
                    state_next = S_FETCH;
                end
            end
`endif
            default: begin
                state_next = S_INIT;
            end
        endcase
        if (!Reset_n) begin
            ir_load = 1'b0;
            PC_Clr  = 1'b0;
            PC_Up   = 1'b0;
            D_Wr    = 1'b0;
            RF_s    = 1'b0;
            RF_W_en = 1'b0;
            ALU_s0  = ALU_PASS;
        end
    end

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - scoreboard bench for proc_ctrl
module tb_proc_ctrl;
    import proc_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] Instr = 16'h0;
`ifdef PROC_CTRL_STEP_EN
    logic        Step = 1'b0;
`endif
    logic        PC_Clr, PC_Up, D_Wr, RF_s, RF_W_en;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, OutState;
    logic [2:0]  ALU_s0;

    proc_ctrl dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Instr      (Instr),
`ifdef PROC_CTRL_STEP_EN
        .Step       (Step),
`endif
        .PC_Clr     (PC_Clr),
        .PC_Up      (PC_Up),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] st;
        logic       pc_clr, pc_up, d_wr, rf_s, rf_w_en, step;
        logic [2:0] alu;
        logic [7:0] d_addr;
        logic [3:0] wa, ra, rb;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_ir;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [15:0] ir);
        exp_t e;
        e = '{st: st, pc_clr: 1'b0, pc_up: 1'b0, d_wr: 1'b0, rf_s: 1'b0, rf_w_en: 1'b0,
              step: 1'b0, alu: 3'd0, d_addr: 8'h0, wa: 4'h0, ra: 4'h0, rb: 4'h0};
        case (ir[15:12])
            4'd1: begin e.d_addr = ir[11:4]; e.ra = ir[3:0]; end
            4'd2: begin e.d_addr = ir[11:4]; e.wa = ir[3:0]; end
            4'd3, 4'd4: begin e.ra = ir[11:8]; e.rb = ir[7:4]; e.wa = ir[3:0]; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic push_done();
`ifdef PROC_CTRL_STEP_EN
        exp_t e;
        sb.push_back(mk(4'd8, model_ir));
        e = mk(4'd8, model_ir);
        e.step = 1'b1;
        sb.push_back(e);
`endif
    endtask

    task automatic build_instr(input logic [15:0] instr, input int halt_cycles);
        exp_t e;
        e = mk(4'd1, model_ir);
        e.pc_up = 1'b1;
        sb.push_back(e);
        model_ir = instr;
        sb.push_back(mk(4'd2, instr));
        case (instr[15:12])
            4'd1: begin
                e = mk(4'd5, instr); e.d_wr = 1'b1; sb.push_back(e); push_done();
            end
            4'd2: begin
                sb.push_back(mk(4'd3, instr));
                e = mk(4'd4, instr); e.rf_s = 1'b1; e.rf_w_en = 1'b1; sb.push_back(e); push_done();
            end
            4'd3, 4'd4: begin
                e = mk(4'd6, instr); e.rf_w_en = 1'b1;
                e.alu = (instr[15:12] == 4'd3) ? 3'd1 : 3'd2;
                sb.push_back(e); push_done();
            end
            4'd5: begin
                for (int i = 0; i < halt_cycles; i++) sb.push_back(mk(4'd7, instr));
            end
            default: push_done();
        endcase
    endtask

    task automatic drain_one();
        exp_t e;
        e = sb.pop_front();
        @(negedge Clk);
        check("state", OutState, e.st);
        check("pc_clr", PC_Clr, e.pc_clr);
        check("pc_up", PC_Up, e.pc_up);
        check("d_wr", D_Wr, e.d_wr);
        check("rf_w_en", RF_W_en, e.rf_w_en);
        check("rf_s", RF_s, e.rf_s);
        check("alu_s0", ALU_s0, e.alu);
        check("d_addr", D_Addr, e.d_addr);
        check("rf_w_addr", RF_W_Addr, e.wa);
        check("rf_ra_addr", RF_Ra_Addr, e.ra);
        check("rf_rb_addr", RF_Rb_Addr, e.rb);
        check("one_write", D_Wr & RF_W_en, 1'b0);
`ifdef PROC_CTRL_STEP_EN
        Step = e.step;
`endif
    endtask

    task automatic drain_all();
        while (sb.size() > 0) drain_one();
    endtask

    task automatic run_instr(input logic [15:0] instr, input int halt_cycles);
        build_instr(instr, halt_cycles);
        Instr = instr;
        drain_all();
    endtask

    task automatic do_reset();
        exp_t e;
        Reset_n = 1'b0;
        model_ir = 16'h0;
        sb.delete();
        repeat (2) begin
            @(negedge Clk);
            check("rst_state", OutState, 4'd0);
            check("rst_enables", {PC_Clr, PC_Up, D_Wr, RF_W_en, RF_s}, 5'b0);
            check("rst_alu", ALU_s0, 3'd0);
            check("rst_addrs", {D_Addr, RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr}, 20'h0);
        end
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        e = mk(4'd0, 16'h0);
        e.pc_clr = 1'b1;
        e.pc_up = 1'b1;
        sb.push_back(e);
        push_done();
        drain_all();
    endtask

    initial begin
        do_reset();
        run_instr(16'h2053, 0);
        run_instr(16'h1A71, 0);
        run_instr(16'h3124, 0);
        run_instr(16'h4124, 0);
        run_instr(16'h0000, 0);
        run_instr(16'hB0FF, 0);
        run_instr(16'h3ABC, 0);
        run_instr(16'h5000, 22);

        #2 Reset_n = 1'b0;
        #1 check("halt_reset_state", OutState, 4'd0);
        check("halt_reset_pc_up", PC_Up, 1'b0);
        do_reset();

        run_instr(16'h1F02, 0);
        build_instr(16'h2077, 0);
        Instr = 16'h2077;
        repeat (3) drain_one();
        #2 Reset_n = 1'b0;
        #1 check("abort_state", OutState, 4'd0);
        check("abort_d_addr", D_Addr, 8'h00);
        sb.delete();
        repeat (3) begin
            @(negedge Clk);
            check("abort_no_write", RF_W_en, 1'b0);
        end
        do_reset();
        run_instr(16'h4ABC, 0);
        run_instr(16'h2FF0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
